instr_controller: RTL and testbench
===================================

# instr_controller

Sequencer between the instruction FIFO and the systolic array datapath. Pops one 64-bit instruction at a time over a valid/ready handshake, decodes it and drives the array and scratchpad memory with cycle-exact control pulses (load weights, load activations, compute plus drain, store results). Accepts the next instruction only when the current one has fully retired.

## Interface
- `ARRAY_SIZE`, default 4: systolic array dimension N.
- `DRAIN_CYCLES`, default 2*ARRAY_SIZE-1: cycles of array flush after the last compute beat.
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `instr_in`  in  64  instruction word from FIFO.
- `instr_valid`  in  1  `instr_in` holds a valid instruction.
- `instr_ready`  out  1  controller can accept an instruction this cycle.
- `mem_ready`  in  1  scratchpad accepts the current rd/wr beat.
- `mem_addr`  out  16  scratchpad beat address.
- `mem_rd_en`  out  1  read beat request.
- `mem_wr_en`  out  1  write beat request.
- `wt_load`  out  1  read data routed to the weight registers (qualifies `mem_rd_en`).
- `act_load`  out  1  read data routed to the activation skew buffers (qualifies `mem_rd_en`).
- `array_en`  out  1  array MAC enable.
- `array_clear`  out  1  one-cycle accumulator clear at COMPUTE start.
- `busy`  out  1  state is not IDLE.
- `halted`  out  1  HALT executed.
- `illegal_instr`  out  1  sticky flag: illegal opcode seen.

## Operation
- Fields: opcode `[63:60]`, addr `[59:44]`, len `[43:28]`, `[27:0]` ignored.
- Opcodes: 0 NOP, 1 LOAD_W, 2 LOAD_A, 3 COMPUTE, 4 STORE, F HALT. Any other opcode is illegal: set `illegal_instr`, drop the word, stay IDLE.
- States: IDLE, LOAD, COMPUTE, DRAIN, STORE, HALT.
- IDLE: `instr_ready`=1. A handshake is `instr_valid && instr_ready`.
- NOP, or any beat opcode with len=0, retires in the accept cycle with no outputs.
- LOAD_W/LOAD_A -> LOAD. `mem_rd_en`=1 with `wt_load` or `act_load`, `mem_addr`=addr.
- Each edge with `mem_rd_en && mem_ready`: addr+1 (wraps mod 2^16), remaining-1. On the final beat, return to IDLE.
- If `mem_ready`=0, all outputs hold.
- COMPUTE: `array_clear` for the first cycle. `array_en`=1 for exactly len cycles (no backpressure), then DRAIN.
- DRAIN: `array_en`=0 for `DRAIN_CYCLES` cycles, then IDLE.
- STORE: same as LOAD with `mem_wr_en`. `wt_load`/`act_load` are 0.
- HALT: `halted`=1, `instr_ready`=0 until `rst`.
- `mem_rd_en` and `mem_wr_en` are never asserted together.

## Timing
- All outputs registered except `instr_ready`, which is `state==IDLE`.
- Reset values: all outputs 0, `mem_addr`=0, state IDLE. `illegal_instr` and `halted` clear only on `rst`.
- Accept at edge k: first beat outputs are valid in cycle k+1.
- With `mem_ready` held high, a LOAD/STORE of len L occupies cycles k+1..k+L. `instr_ready` rises in cycle k+L+1.
- COMPUTE of len L: `array_en` covers cycles k+1..k+L, `array_clear` is in cycle k+1, and `instr_ready` returns in cycle k+L+DRAIN_CYCLES+1.
- Back-to-back: an instruction accepted in the first IDLE cycle starts its first beat the following cycle. This gives one bubble cycle between instructions.
- `rst` mid-operation aborts the instruction in flight. Outputs are 0 the cycle after the reset edge, and the counters clear.
- len is 16-bit unsigned; max 65535 beats. The address counter is 16-bit and wraps silently.

## Structure
- Package `ctrl_pkg`: opcode localparams, field bit positions, state encoding, `ADDR_W`=16, `LEN_W`=16.
- Sub-module `burst_counter`:
  - Inputs: load addr/len, step enable.
  - Outputs: current addr, `last` flag.
  - Shared by LOAD, STORE and COMPUTE (address ignored for COMPUTE).
  - DRAIN reuses the same counter loaded with `DRAIN_CYCLES`.

## Test plan
- LOAD_W addr=0x0010 len=3, `mem_ready`=1 -> `mem_rd_en`+`wt_load` for 3 cycles with addr 0x10/0x11/0x12. `instr_ready` returns 4 cycles after accept.
- STORE addr=0xFFFE len=4, `mem_ready` low for 2 cycles after the 2nd beat -> addr 0xFFFE, 0xFFFF, (hold 2), 0x0000, 0x0001. Exactly 4 accepted beats.
- COMPUTE len=5, ARRAY_SIZE=4 -> `array_clear` in cycle 1, `array_en` for 5 cycles, 7 drain cycles. `instr_ready` back 13 cycles after accept.
- Opcode 0x7, then NOP, then LOAD_A len=0 -> `illegal_instr`=1 (stays set). Each instruction accepted in a single cycle, no memory beats.
- LOAD_A len=8 with `rst` asserted on beat 3 -> all outputs 0 the next cycle, state IDLE. A subsequent LOAD_A starts cleanly at its own address.
- HALT followed by `instr_valid`=1 -> `halted`=1, `instr_ready` stays 0 for 20 cycles. Cleared by `rst`.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the instruction controller: opcodes, instruction
// field positions, FSM state encoding and counter widths.
package ctrl_pkg;

    localparam int ADDR_W = 16;
    localparam int LEN_W  = 16;

    localparam int OP_HI   = 63;
    localparam int OP_LO   = 60;
    localparam int ADDR_HI = 59;
    localparam int ADDR_LO = 44;
    localparam int LEN_HI  = 43;
    localparam int LEN_LO  = 28;

    localparam logic [3:0] OP_NOP     = 4'h0;
    localparam logic [3:0] OP_LOAD_W  = 4'h1;
    localparam logic [3:0] OP_LOAD_A  = 4'h2;
    localparam logic [3:0] OP_COMPUTE = 4'h3;
    localparam logic [3:0] OP_STORE   = 4'h4;
    localparam logic [3:0] OP_HALT    = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_COMPUTE = 3'd2,
        S_DRAIN   = 3'd3,
        S_STORE   = 3'd4,
        S_HALT    = 3'd5
    } state_t;

    function automatic logic opcode_legal(input logic [3:0] op);
        return (op == OP_NOP) || (op == OP_LOAD_W) || (op == OP_LOAD_A) ||
               (op == OP_COMPUTE) || (op == OP_STORE) || (op == OP_HALT);
    endfunction

endpackage

// File: rtl/burst_counter.sv
// Address/length counter shared by memory bursts, compute beats and drain.
// `last` marks the cycle in which the final remaining beat is presented.
module burst_counter
    import ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [LEN_W-1:0]  load_len,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [LEN_W-1:0] remain;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr   <= '0;
            remain <= '0;
        end else if (load) begin
            addr   <= load_addr;
            remain <= load_len;
        end else if (step) begin
            addr <= addr + 1'b1;
            if (remain != '0)
                remain <= remain - 1'b1;
        end
    end

    assign last = (remain == LEN_W'(1));

endmodule

// File: rtl/instr_controller.sv
// Instruction sequencer: pops one instruction at a time and drives registered
// control pulses to the scratchpad and systolic array until it retires.
module instr_controller
    import ctrl_pkg::*;
#(
    parameter int ARRAY_SIZE   = 4,
    parameter int DRAIN_CYCLES = 2 * ARRAY_SIZE - 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [63:0]       instr_in,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic              wt_load,
    output logic              act_load,
    output logic              array_en,
    output logic              array_clear,
    output logic              busy,
    output logic              halted,
    output logic              illegal_instr
);

    state_t state, state_next;

    logic [3:0]        op;
    logic [ADDR_W-1:0] f_addr;
    logic [LEN_W-1:0]  f_len;
    logic              accept;
    logic              unused_bits;

    logic              cnt_load, cnt_step, cnt_last;
    logic [ADDR_W-1:0] cnt_addr;
    logic [LEN_W-1:0]  cnt_len;

    logic wt_sel, wt_sel_next;
    logic rd_d, wr_d, wt_d, act_d, en_d, clr_d, busy_d, halt_d, ill_d;

    assign op          = instr_in[OP_HI:OP_LO];
    assign f_addr      = instr_in[ADDR_HI:ADDR_LO];
    assign f_len       = instr_in[LEN_HI:LEN_LO];
    assign unused_bits = ^instr_in[LEN_LO-1:0];

    assign instr_ready = (state == S_IDLE);
    assign accept      = instr_valid && instr_ready;

    burst_counter u_cnt (
        .clk       (clk),
        .rst       (rst),
        .load      (cnt_load),
        .load_addr (cnt_addr),
        .load_len  (cnt_len),
        .step      (cnt_step),
        .addr      (mem_addr),
        .last      (cnt_last)
    );

    // State and all outputs except instr_ready are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            wt_sel        <= 1'b0;
            mem_rd_en     <= 1'b0;
            mem_wr_en     <= 1'b0;
            wt_load       <= 1'b0;
            act_load      <= 1'b0;
            array_en      <= 1'b0;
            array_clear   <= 1'b0;
            busy          <= 1'b0;
            halted        <= 1'b0;
            illegal_instr <= 1'b0;
        end else begin
            state         <= state_next;
            wt_sel        <= wt_sel_next;
            mem_rd_en     <= rd_d;
            mem_wr_en     <= wr_d;
            wt_load       <= wt_d;
            act_load      <= act_d;
            array_en      <= en_d;
            array_clear   <= clr_d;
            busy          <= busy_d;
            halted        <= halt_d;
            illegal_instr <= ill_d;
        end
    end

    always_comb begin
        state_next = state;
        cnt_load   = 1'b0;
        cnt_step   = 1'b0;
        cnt_addr   = f_addr;
        cnt_len    = f_len;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_LOAD_W, OP_LOAD_A: if (f_len != '0) begin
                            state_next = S_LOAD;
                            cnt_load   = 1'b1;
                        end
                        OP_STORE: if (f_len != '0) begin
                            state_next = S_STORE;
                            cnt_load   = 1'b1;
                        end
                        OP_COMPUTE: if (f_len != '0) begin
                            state_next = S_COMPUTE;
                            cnt_load   = 1'b1;
                        end
                        OP_HALT: state_next = S_HALT;
                        default: state_next = S_IDLE;
                    endcase
                end
            end
            S_LOAD, S_STORE: begin
                cnt_step = mem_ready;
                if (mem_ready && cnt_last)
                    state_next = S_IDLE;
            end
            S_COMPUTE: begin
                cnt_step = 1'b1;
                if (cnt_last) begin
                    if (DRAIN_CYCLES == 0) begin
                        state_next = S_IDLE;
                    end else begin
                        // Same counter paces the flush; address is irrelevant here.
                        state_next = S_DRAIN;
                        cnt_load   = 1'b1;
                        cnt_addr   = mem_addr;
                        cnt_len    = LEN_W'(DRAIN_CYCLES);
                    end
                end
            end
            S_DRAIN: begin
                cnt_step = 1'b1;
                if (cnt_last)
                    state_next = S_IDLE;
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        wt_sel_next = (state == S_IDLE) ? (op == OP_LOAD_W) : wt_sel;
        rd_d   = (state_next == S_LOAD);
        wr_d   = (state_next == S_STORE);
        wt_d   = rd_d && wt_sel_next;
        act_d  = rd_d && !wt_sel_next;
        en_d   = (state_next == S_COMPUTE);
        clr_d  = (state == S_IDLE) && (state_next == S_COMPUTE);
        busy_d = (state_next != S_IDLE);
        halt_d = halted || (state_next == S_HALT);
        ill_d  = illegal_instr || (accept && !opcode_legal(op));
    end

endmodule

// File: tb/tb_instr_controller.sv
// Directed bench for instr_controller: bursts, backpressure, compute/drain,
// illegal and zero-length words, mid-burst reset and HALT.
module tb_instr_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] instr_in;
    logic        instr_valid;
    logic        instr_ready;
    logic        mem_ready;
    logic [15:0] mem_addr;
    logic        mem_rd_en, mem_wr_en, wt_load, act_load;
    logic        array_en, array_clear, busy, halted, illegal_instr;

    int n_chk  = 0;
    int n_fail = 0;

    instr_controller dut (
        .clk           (clk),
        .rst           (rst),
        .instr_in      (instr_in),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .mem_ready     (mem_ready),
        .mem_addr      (mem_addr),
        .mem_rd_en     (mem_rd_en),
        .mem_wr_en     (mem_wr_en),
        .wt_load       (wt_load),
        .act_load      (act_load),
        .array_en      (array_en),
        .array_clear   (array_clear),
        .busy          (busy),
        .halted        (halted),
        .illegal_instr (illegal_instr)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mk(input logic [3:0] op, input logic [15:0] a,
                                       input logic [15:0] l);
        return {op, a, l, 28'h0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Order: rd wr wt act en clr busy halted illegal ready
    task automatic ctl(input string tag, input logic [9:0] exp);
        logic [9:0] obs;
        obs = {mem_rd_en, mem_wr_en, wt_load, act_load, array_en, array_clear,
               busy, halted, illegal_instr, instr_ready};
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: ctl observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic adr(input string tag, input logic [15:0] exp);
        n_chk++;
        assert (mem_addr === exp) else begin
            n_fail++;
            $error("FAIL %s: mem_addr observed %h expected %h", tag, mem_addr, exp);
        end
    endtask

    localparam logic [9:0] IDLE_OK = 10'b0000000001;
    localparam logic [9:0] RD_W    = 10'b1010001000;
    localparam logic [9:0] RD_A    = 10'b1001001000;
    localparam logic [9:0] WR      = 10'b0100001000;
    localparam logic [9:0] CMP1    = 10'b0000111000;
    localparam logic [9:0] CMP     = 10'b0000101000;
    localparam logic [9:0] DRN     = 10'b0000001000;
    localparam logic [9:0] ILL_IDL = 10'b0000000011;
    localparam logic [9:0] HLT     = 10'b0000001100;

    initial begin
        rst = 1'b1; instr_valid = 1'b0; instr_in = '0; mem_ready = 1'b1;
        step(); step();
        ctl("reset_ctl", IDLE_OK);
        adr("reset_addr", 16'h0000);
        rst = 1'b0;
        step();

        // LOAD_W 0x10 len 3
        instr_in = mk(4'h1, 16'h0010, 16'd3); instr_valid = 1'b1;
        step(); instr_valid = 1'b0;
        ctl("ldw_b1", RD_W); adr("ldw_a1", 16'h0010);
        step(); ctl("ldw_b2", RD_W); adr("ldw_a2", 16'h0011);
        step(); ctl("ldw_b3", RD_W); adr("ldw_a3", 16'h0012);
        step(); ctl("ldw_done", IDLE_OK);

        // STORE 0xFFFE len 4 with two stall cycles on the third beat
        instr_in = mk(4'h4, 16'hFFFE, 16'd4); instr_valid = 1'b1;
        step(); instr_valid = 1'b0;
        ctl("st_b1", WR); adr("st_a1", 16'hFFFE);
        step(); ctl("st_b2", WR); adr("st_a2", 16'hFFFF);
        step(); mem_ready = 1'b0; ctl("st_b3", WR); adr("st_a3", 16'h0000);
        step(); ctl("st_hold", WR); adr("st_hold_a", 16'h0000);
        step(); mem_ready = 1'b1; ctl("st_hold2", WR); adr("st_hold2_a", 16'h0000);
        step(); ctl("st_b4", WR); adr("st_a4", 16'h0001);
        step(); ctl("st_done", IDLE_OK);

        // COMPUTE len 5: clear once, 5 enable cycles, 7 drain cycles
        instr_in = mk(4'h3, 16'h0000, 16'd5); instr_valid = 1'b1;
        step(); instr_valid = 1'b0;
        ctl("cmp_c1", CMP1);
        for (int i = 2; i <= 5; i++) begin
            step(); ctl($sformatf("cmp_c%0d", i), CMP);
        end
        for (int i = 6; i <= 12; i++) begin
            step(); ctl($sformatf("drain_c%0d", i), DRN);
        end
        step(); ctl("cmp_done_c13", IDLE_OK);

        // Illegal opcode, NOP, zero-length LOAD_A: each accepted in one cycle
        instr_in = mk(4'h7, 16'h1234, 16'd2); instr_valid = 1'b1;
        step(); ctl("illegal", ILL_IDL);
        instr_in = mk(4'h0, 16'h1234, 16'd2);
        step(); ctl("nop", ILL_IDL);
        instr_in = mk(4'h2, 16'h1234, 16'd0);
        step(); ctl("lda_len0", ILL_IDL);
        instr_valid = 1'b0;
        step(); ctl("ill_sticky", ILL_IDL);

        // LOAD_A len 8 aborted by reset on beat 3
        instr_in = mk(4'h2, 16'h0200, 16'd8); instr_valid = 1'b1;
        step(); instr_valid = 1'b0;
        ctl("lda_b1", RD_A | 10'b0000000010); adr("lda_a1", 16'h0200);
        step(); adr("lda_a2", 16'h0201);
        step(); adr("lda_a3", 16'h0202);
        rst = 1'b1;
        step(); rst = 1'b0;
        ctl("abort_ctl", IDLE_OK); adr("abort_addr", 16'h0000);
        instr_in = mk(4'h2, 16'h0300, 16'd2); instr_valid = 1'b1;
        step(); instr_valid = 1'b0;
        ctl("lda2_b1", RD_A); adr("lda2_a1", 16'h0300);
        step(); adr("lda2_a2", 16'h0301);
        step(); ctl("lda2_done", IDLE_OK);

        // Back-to-back: next word offered in the first IDLE cycle
        instr_in = mk(4'h1, 16'h0040, 16'd1); instr_valid = 1'b1;
        step(); ctl("b2b_1", RD_W); adr("b2b_a1", 16'h0040);
        instr_in = mk(4'h2, 16'h0050, 16'd1);
        step(); ctl("b2b_bubble", IDLE_OK);
        step(); instr_valid = 1'b0;
        ctl("b2b_2", RD_A); adr("b2b_a2", 16'h0050);
        step(); ctl("b2b_done", IDLE_OK);

        // HALT, then further valid words are refused until reset
        instr_in = mk(4'hF, 16'h0000, 16'd0); instr_valid = 1'b1;
        step();
        instr_in = mk(4'h1, 16'h0000, 16'd3);
        for (int i = 0; i < 20; i++) begin
            ctl($sformatf("halt_c%0d", i), HLT);
            step();
        end
        rst = 1'b1; instr_valid = 1'b0;
        step(); rst = 1'b0;
        ctl("halt_cleared", IDLE_OK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
